// File: rtl/mastermind_if.sv
// Guess/feedback channel between the Mastermind code-breaker and the game datapath.
// The guesser drives guesses. The game side accepts each guess and answers with red/white pegs.
interface mastermind_if;
    logic [11:0] guess;
    logic        guess_valid;
    logic        guess_ready;
    logic        feedback_valid;
    logic [2:0]  red;
    logic [2:0]  white;

    modport master (
        output guess,
        output guess_valid,
        input  guess_ready,
        input  feedback_valid,
        input  red,
        input  white
    );

    modport slave (
        input  guess,
        input  guess_valid,
        output guess_ready,
        output feedback_valid,
        output red,
        output white
    );
endinterface

// File: rtl/mastermind_solver.sv
// Automatic Mastermind code-breaker. It scans codes upward from the last guess and offers the
// first code that is consistent with every stored guess/feedback pair.
module mastermind_solver #(
    parameter int MAX_GUESSES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    mastermind_if.master        game,
    output logic [3:0]          guess_count,
    output logic                busy,
    output logic                done,
    output logic                solved,
    output logic                error
);

    localparam int IDX_W = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
    localparam int CNT_W = $clog2(MAX_GUESSES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_OFFER,
        S_WAIT_FB,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state, state_n;
    logic [11:0]      cand, cand_n;
    logic [11:0]      guess_q, guess_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] hist_cnt, hist_cnt_n;
    logic [3:0]       count_n;
    logic             done_n, solved_n, error_n;
    logic             hist_we;

    logic [11:0]      hist_guess [MAX_GUESSES];
    logic [2:0]       hist_red   [MAX_GUESSES];
    logic [2:0]       hist_white [MAX_GUESSES];

    logic [5:0]       cand_score;
    logic             hist_hit;
    logic             idx_last;
    logic [3:0]       fb_sum;
    logic             fb_illegal;

    // Standard Mastermind scoring. White counts the shared colours minus the exact hits.
    function automatic logic [5:0] score(input logic [11:0] a, input logic [11:0] b);
        logic [2:0] r;
        logic [2:0] total;
        logic [2:0] ca;
        logic [2:0] cb;
        r     = 3'd0;
        total = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (a[3*i +: 3] == b[3*i +: 3]) r = r + 3'd1;
        end
        for (int c = 0; c < 8; c++) begin
            ca = 3'd0;
            cb = 3'd0;
            for (int i = 0; i < 4; i++) begin
                if (a[3*i +: 3] == 3'(c)) ca = ca + 3'd1;
                if (b[3*i +: 3] == 3'(c)) cb = cb + 3'd1;
            end
            total = total + ((ca < cb) ? ca : cb);
        end
        return {r, total - r};
    endfunction

    assign cand_score = score(cand, hist_guess[idx]);
    assign hist_hit   = (cand_score == {hist_red[idx], hist_white[idx]});
    assign idx_last   = ((CNT_W'(idx) + CNT_W'(1)) == hist_cnt);
    assign fb_sum     = {1'b0, game.red} + {1'b0, game.white};
    assign fb_illegal = (game.red > 3'd4) || (fb_sum > 4'd4) ||
                        ((game.red == 3'd3) && (game.white == 3'd1));

    assign game.guess       = guess_q;
    assign game.guess_valid = (state == S_OFFER);
    assign busy             = (state == S_SEARCH) || (state == S_OFFER) || (state == S_WAIT_FB);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cand        <= '0;
            idx         <= '0;
            hist_cnt    <= '0;
            guess_q     <= '0;
            guess_count <= '0;
            done        <= 1'b0;
            solved      <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            idx         <= idx_n;
            hist_cnt    <= hist_cnt_n;
            guess_q     <= guess_n;
            guess_count <= count_n;
            done        <= done_n;
            solved      <= solved_n;
            error       <= error_n;
        end
    end

    // History contents need no reset because only entries below hist_cnt are ever read.
    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_guess[hist_cnt[IDX_W-1:0]] <= cand;
            hist_red[hist_cnt[IDX_W-1:0]]   <= game.red;
            hist_white[hist_cnt[IDX_W-1:0]] <= game.white;
        end
    end

    always_comb begin
        state_n    = state;
        cand_n     = cand;
        idx_n      = idx;
        hist_cnt_n = hist_cnt;
        guess_n    = guess_q;
        count_n    = guess_count;
        done_n     = done;
        solved_n   = solved;
        error_n    = error;
        hist_we    = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    hist_cnt_n = '0;
                    cand_n     = '0;
                    idx_n      = '0;
                    count_n    = '0;
                    done_n     = 1'b0;
                    solved_n   = 1'b0;
                    error_n    = 1'b0;
                    state_n    = S_SEARCH;
                end
            end

            S_SEARCH: begin
                if (hist_cnt == '0) begin
                    guess_n = cand;
                    state_n = S_OFFER;
                end else if (hist_hit) begin
                    if (idx_last) begin
                        guess_n = cand;
                        state_n = S_OFFER;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else if (cand == 12'hFFF) begin
                    // The scan never wraps, so running off the top means the feedback contradicts itself.
                    error_n = 1'b1;
                    state_n = S_ERROR;
                end else begin
                    cand_n = cand + 12'd1;
                    idx_n  = '0;
                end
            end

            S_OFFER: begin
                if (game.guess_ready) begin
                    count_n = guess_count + 4'd1;
                    state_n = S_WAIT_FB;
                end
            end

            S_WAIT_FB: begin
                if (game.feedback_valid) begin
                    if (fb_illegal) begin
                        error_n = 1'b1;
                        state_n = S_ERROR;
                    end else begin
                        hist_we    = 1'b1;
                        hist_cnt_n = hist_cnt + CNT_W'(1);
                        if (game.red == 3'd4) begin
                            done_n   = 1'b1;
                            solved_n = 1'b1;
                            state_n  = S_DONE;
                        end else if (guess_count == 4'(MAX_GUESSES)) begin
                            done_n  = 1'b1;
                            state_n = S_DONE;
                        end else if (cand == 12'hFFF) begin
                            error_n = 1'b1;
                            state_n = S_ERROR;
                        end else begin
                            cand_n  = cand + 12'd1;
                            idx_n   = '0;
                            state_n = S_SEARCH;
                        end
                    end
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mastermind_solver.sv
// Directed scoreboard bench for mastermind_solver. Expected guesses are queued as each game
// is driven. They are then checked against the guesses the solver offers.
module tb_mastermind_solver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start0, start1;
    logic [3:0] cnt0, cnt1;
    logic       busy0, busy1, done0, done1, solved0, solved1, error0, error1;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [11:0] exp_q [$];

    mastermind_if bus0 ();
    mastermind_if bus1 ();

    mastermind_solver #(.MAX_GUESSES(8)) dut (
        .clk(clk), .reset(reset), .start(start0), .game(bus0),
        .guess_count(cnt0), .busy(busy0), .done(done0), .solved(solved0), .error(error0)
    );

    mastermind_solver #(.MAX_GUESSES(2)) dut_short (
        .clk(clk), .reset(reset), .start(start1), .game(bus1),
        .guess_count(cnt1), .busy(busy1), .done(done1), .solved(solved1), .error(error1)
    );

    function automatic logic gv(int w);
        return (w != 0) ? bus1.guess_valid : bus0.guess_valid;
    endfunction

    function automatic logic [11:0] gs(int w);
        return (w != 0) ? bus1.guess : bus0.guess;
    endfunction

    function automatic logic [3:0] cnt(int w);
        return (w != 0) ? cnt1 : cnt0;
    endfunction

    // Status is packed as {busy, done, solved, error}.
    function automatic logic [3:0] status(int w);
        return (w != 0) ? {busy1, done1, solved1, error1} : {busy0, done0, solved0, error0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(string tag, logic [15:0] obs, logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int w, logic st, logic rdy, logic fbv, logic [2:0] r, logic [2:0] wh);
        if (w != 0) begin
            start1 = st; bus1.guess_ready = rdy; bus1.feedback_valid = fbv;
            bus1.red = r; bus1.white = wh;
        end else begin
            start0 = st; bus0.guess_ready = rdy; bus0.feedback_valid = fbv;
            bus0.red = r; bus0.white = wh;
        end
    endtask

    task automatic apply_start(int w);
        drive(w, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        tick();
        drive(w, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic apply_accept(int w);
        drive(w, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
        tick();
        drive(w, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic apply_feedback(int w, logic [2:0] r, logic [2:0] wh);
        drive(w, 1'b0, 1'b0, 1'b1, r, wh);
        tick();
        drive(w, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic wait_guess(int w, string tag);
        int cyc;
        logic [11:0] exp;
        cyc = 0;
        while (!gv(w) && cyc < 5000) begin
            tick();
            cyc++;
        end
        if (exp_q.size() == 0) begin
            n_asserts++;
            n_fail++;
            $display("[TB] FAIL %s observed=guess 0x%0h expected=nothing queued", tag, gs(w));
        end else begin
            exp = exp_q.pop_front();
            if (!gv(w)) begin
                n_asserts++;
                n_fail++;
                $display("[TB] FAIL %s observed=no guess_valid in 5000 cycles expected=guess 0x%0h", tag, exp);
            end else begin
                check_output(tag, 16'(gs(w)), 16'(exp));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        repeat (3) tick();
        check_output("rst_guess", 16'(gs(0)), 16'h000);
        check_output("rst_valid", 16'(gv(0)), 16'h0);
        check_output("rst_status", 16'(status(0)), 16'h0);
        check_output("rst_count", 16'(cnt(0)), 16'h0);
        reset = 1'b0;
        tick();

        // Secret 000: first guess is 000, appears exactly two cycles after start.
        exp_q.push_back(12'h000);
        apply_start(0);
        check_output("t1_lat_search", 16'(gv(0)), 16'h0);
        tick();
        check_output("t1_lat_offer", 16'(gv(0)), 16'h1);
        wait_guess(0, "t1_guess");
        apply_accept(0);
        apply_feedback(0, 3'd4, 3'd0);
        check_output("t1_status", 16'(status(0)), 16'h6);
        check_output("t1_count", 16'(cnt(0)), 16'h1);

        // Secret 001: 3 reds on 000 leads straight to 001.
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h001);
        apply_start(0);
        wait_guess(0, "t2_guess1");
        apply_accept(0);
        apply_feedback(0, 3'd3, 3'd0);
        wait_guess(0, "t2_guess2");
        check_output("t2_count_offer", 16'(cnt(0)), 16'h1);
        apply_accept(0);
        apply_feedback(0, 3'd4, 3'd0);
        check_output("t2_status", 16'(status(0)), 16'h6);
        check_output("t2_count", 16'(cnt(0)), 16'h2);
        check_output("t2_guess_hold", 16'(gs(0)), 16'h001);
        check_output("t2_valid_low", 16'(gv(0)), 16'h0);

        // Secret 240 (digits 0,0,1,1): exercises white scoring via the 009 probe.
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h009);
        exp_q.push_back(12'h240);
        apply_start(0);
        wait_guess(0, "t3_guess1");
        apply_accept(0);
        apply_feedback(0, 3'd2, 3'd0);
        wait_guess(0, "t3_guess2");
        apply_accept(0);
        apply_feedback(0, 3'd0, 3'd4);
        wait_guess(0, "t3_guess3");
        apply_accept(0);
        apply_feedback(0, 3'd4, 3'd0);
        check_output("t3_status", 16'(status(0)), 16'h6);
        check_output("t3_count", 16'(cnt(0)), 16'h3);

        // Backpressure with stray feedback pulses, then reset while waiting for feedback.
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h249);
        apply_start(0);
        wait_guess(0, "bp_guess1");
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd0);
            tick();
            check_output("bp_guess_hold", 16'(gs(0)), 16'h000);
            check_output("bp_valid_hold", 16'(gv(0)), 16'h1);
            check_output("bp_count_hold", 16'(cnt(0)), 16'h0);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        apply_accept(0);
        check_output("bp_count_accept", 16'(cnt(0)), 16'h1);
        apply_feedback(0, 3'd0, 3'd0);
        wait_guess(0, "bp_guess2");
        apply_accept(0);
        check_output("rst_mid_pre_count", 16'(cnt(0)), 16'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("rst_mid_guess", 16'(gs(0)), 16'h000);
        check_output("rst_mid_valid", 16'(gv(0)), 16'h0);
        check_output("rst_mid_status", 16'(status(0)), 16'h0);
        check_output("rst_mid_count", 16'(cnt(0)), 16'h0);
        exp_q.push_back(12'h000);
        apply_start(0);
        wait_guess(0, "rst_new_guess");
        apply_accept(0);
        check_output("rst_new_count", 16'(cnt(0)), 16'h1);
        apply_feedback(0, 3'd4, 3'd0);

        // Illegal feedback: 2/3 (sum > 4), then restart, then 3/1.
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h000);
        apply_start(0);
        wait_guess(0, "ill_guess1");
        apply_accept(0);
        apply_feedback(0, 3'd2, 3'd3);
        check_output("ill23_status", 16'(status(0)), 16'h1);
        apply_start(0);
        check_output("ill_restart_status", 16'(status(0)), 16'h8);
        wait_guess(0, "ill_guess2");
        apply_accept(0);
        apply_feedback(0, 3'd3, 3'd1);
        check_output("ill31_status", 16'(status(0)), 16'h1);

        // Guess budget of 2 on the short instance, secret 777.
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h249);
        apply_start(1);
        wait_guess(1, "bud_guess1");
        apply_accept(1);
        apply_feedback(1, 3'd0, 3'd0);
        wait_guess(1, "bud_guess2");
        apply_accept(1);
        apply_feedback(1, 3'd0, 3'd0);
        check_output("bud_status", 16'(status(1)), 16'h4);
        check_output("bud_count", 16'(cnt(1)), 16'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
